// File: rtl/queue_pkg.sv
// Shared queue definitions: default geometry common to the FIFO and the stack,
// and the error-cause encoding retained for debug visibility.
package queue_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2
  } err_cause_e;

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_WIDTH storage with one synchronous write port and one registered
// read port. The array itself is never reset; only the read register is.
module fifo_regfile
  import queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // A write coinciding with reset is dropped so reset aborts the operation cleanly.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_queue.sv
// Fixed-depth synchronous FIFO: wrap-bit pointers, accept/reject decode,
// sticky error register and status derived only from the registered pointers.
module fifo_queue
  import queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  error,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  logic [ADDR_WIDTH:0] wr_ptr_reg;
  logic [ADDR_WIDTH:0] rd_ptr_reg;
  err_cause_e          err_cause_reg;
  err_cause_e          err_cause_next;
  logic                push_ok;
  logic                pop_ok;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]);
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign error = (err_cause_reg != ERR_NONE);

  // A simultaneous pop frees the head slot, so a push into a full FIFO is still accepted.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    err_cause_next = err_cause_reg;
    if (push && !push_ok) begin
      err_cause_next = ERR_OVERFLOW;
    end else if (pop && !pop_ok) begin
      err_cause_next = ERR_UNDERFLOW;
    end else if (push_ok || pop_ok) begin
      err_cause_next = ERR_NONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      err_cause_reg <= ERR_NONE;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      err_cause_reg <= err_cause_next;
    end
  end

  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_reg[ADDR_WIDTH-1:0]),
    .wr_data (data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr_reg[ADDR_WIDTH-1:0]),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_fifo_queue.sv
// Self-checking bench for fifo_queue: table-driven vectors with constant expectations
// plus a queue-based scoreboard for read data ordering.
module tb_fifo_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       error;
  logic       full;
  logic       empty;
  logic [4:0] count;

  int checks = 0;
  int fails  = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       err;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[12];

  fifo_queue dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (data_out),
    .error    (error),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Drive one cycle; the reference queue predicts acceptance and the scoreboard holds read data.
  task automatic do_cycle(input logic p, input logic q, input logic [7:0] d);
    logic pop_acc;
    logic push_acc;
    @(negedge clk);
    push = p;
    pop = q;
    data_in = d;
    pop_acc  = q && (model_q.size() > 0);
    push_acc = p && ((model_q.size() < 16) || pop_acc);
    if (pop_acc) exp_q.push_back(model_q.pop_front());
    if (push_acc) model_q.push_back(d);
    @(posedge clk);
    #1;
    $display("cycle push=%0d pop=%0d din=%02h -> dout=%02h count=%0d full=%0d empty=%0d err=%0d",
             p, q, d, data_out, count, full, empty, error);
    if (pop_acc) chk("scoreboard_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
    chk("model_count", {27'd0, count}, model_q.size());
  endtask

  task automatic chk_status(input string tag, input logic [4:0] c, input logic e,
                            input logic f, input logic er);
    chk({tag, "_count"}, {27'd0, count}, {27'd0, c});
    chk({tag, "_empty"}, {31'd0, empty}, {31'd0, e});
    chk({tag, "_full"},  {31'd0, full},  {31'd0, f});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, er});
  endtask

  initial begin
    // Tests 1, 2 and 4 as constant-expectation vectors.
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 8'h22, 5'd2, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 8'h33, 5'd3, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 5'd2, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 8'h22};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h33};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 8'h33};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 8'h33};
    vecs[9]  = '{1'b1, 1'b1, 8'h5A, 5'd1, 1'b0, 1'b0, 1'b1, 8'h33};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h5A};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h5A};

    reset = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    data_in = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_status("reset", 5'd0, 1'b1, 1'b0, 1'b0);
    chk("reset_dout", {24'd0, data_out}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      do_cycle(vecs[i].push, vecs[i].pop, vecs[i].din);
      chk_status($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].err);
      chk($sformatf("vec%0d_dout", i), {24'd0, data_out}, {24'd0, vecs[i].dout});
    end

    // Test 3: fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 1'b0, 8'(i));
    chk_status("filled", 5'd16, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b0, 8'hAA);
    chk_status("overflow", 5'd16, 1'b0, 1'b1, 1'b1);
    do_cycle(1'b0, 1'b0, 8'h00);
    chk("overflow_sticky", {31'd0, error}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      do_cycle(1'b0, 1'b1, 8'h00);
      chk($sformatf("drain%0d", i), {24'd0, data_out}, i);
    end
    chk_status("drained", 5'd0, 1'b1, 1'b0, 1'b0);

    // Test 5: push and pop together while full; pointers wrap.
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 1'b0, 8'(8'h80 + i));
    do_cycle(1'b1, 1'b1, 8'h77);
    chk_status("full_pushpop", 5'd16, 1'b0, 1'b1, 1'b0);
    chk("full_pushpop_dout", {24'd0, data_out}, 32'h80);
    for (int i = 1; i < 16; i++) begin
      do_cycle(1'b0, 1'b1, 8'h00);
      chk($sformatf("wrap_drain%0d", i), {24'd0, data_out}, 32'h80 + i);
    end
    do_cycle(1'b0, 1'b1, 8'h00);
    chk("wrap_last", {24'd0, data_out}, 32'h77);
    chk_status("wrap_empty", 5'd0, 1'b1, 1'b0, 1'b0);

    // Test 6: asynchronous reset mid-cycle with count=5 and push held.
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 8'(8'hC0 + i));
    chk("pre_reset_count", {27'd0, count}, 32'd5);
    @(negedge clk);
    push = 1'b1;
    data_in = 8'hEE;
    #2;
    reset = 1'b1;
    #1;
    chk_status("async_reset", 5'd0, 1'b1, 1'b0, 1'b0);
    chk("async_reset_dout", {24'd0, data_out}, 32'h0);
    model_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("reset_held_count", {27'd0, count}, 32'd0);
    @(negedge clk);
    push = 1'b0;
    reset = 1'b0;
    do_cycle(1'b0, 1'b0, 8'h00);
    chk_status("post_reset", 5'd0, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 8'h00);
    chk_status("post_reset_pop", 5'd0, 1'b1, 1'b0, 1'b1);
    chk("post_reset_dout", {24'd0, data_out}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
